// File: rtl/tmodel_iter.sv
// Iterative XOR-butterfly / bit-reverse transform over an N-bit vector.
// One vector in flight; the result is held on the output until the consumer takes it.
module tmodel_iter #(
    parameter int N      = 98,
    parameter int STAGES = 7
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    input  logic [1:0]   in_mode,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_data,
    output logic [1:0]   out_mode,
    output logic         busy
);

    localparam int SW = $clog2(STAGES + 1);

    if (N < 2 || STAGES < 1 || (2 ** STAGES) < N) begin : g_bad_params
        $error("tmodel_iter: need N >= 2, STAGES >= 1 and 2**STAGES >= N");
    end

    // state | meaning
    // IDLE  | waiting for a vector, in_ready high
    // RUN   | one butterfly stage per edge
    // REV   | final bit-reverse for mode 11
    // DONE  | result presented until out_ready
    typedef enum logic [1:0] {IDLE, RUN, REV, DONE} state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    w_q, w_d;
    logic [1:0]      mode_q, mode_d;
    logic [SW-1:0]   stage_q, stage_d;
    logic [N-1:0]    bf [STAGES];
    logic [N-1:0]    bf_sel;

    function automatic logic [N-1:0] bit_rev(input logic [N-1:0] v);
        logic [N-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) begin
            r[i] = v[N-1-i];
        end
        return r;
    endfunction

    // Bits whose index has bit k clear; partners past the top shift in as zero.
    function automatic logic [N-1:0] stage_mask(input int k);
        logic [N-1:0] m;
        m = '0;
        for (int i = 0; i < N; i++) begin
            m[i] = (((i >> k) & 1) == 0);
        end
        return m;
    endfunction

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        assign bf[k] = w_q ^ ((w_q >> (1 << k)) & stage_mask(k));
    end

    always_comb begin
        bf_sel = w_q;
        for (int k = 0; k < STAGES; k++) begin
            if (stage_q == SW'(k)) begin
                bf_sel = bf[k];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        mode_d  = mode_q;
        stage_d = stage_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    mode_d  = in_mode;
                    stage_d = '0;
                    w_d     = (in_mode == 2'b01) ? bit_rev(in_data) : in_data;
                    state_d = in_mode[1] ? RUN : DONE;
                end
            end
            RUN: begin
                w_d     = bf_sel;
                stage_d = stage_q + SW'(1);
                if (stage_q == SW'(STAGES - 1)) begin
                    state_d = mode_q[0] ? REV : DONE;
                end
            end
            REV: begin
                w_d     = bit_rev(w_q);
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            w_q     <= '0;
            mode_q  <= 2'b00;
            stage_q <= '0;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            mode_q  <= mode_d;
            stage_q <= stage_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_data  = w_q;
    assign out_mode  = mode_q;

endmodule

// File: tb/tb_tmodel_iter.sv
// Directed table plus corner sequences for tmodel_iter at N=8/STAGES=3 and default N=98.
module tb_tmodel_iter;

    logic clk = 1'b0;
    logic rst_n;

    logic        iv8, ir8, ov8, or8, busy8;
    logic [7:0]  id8, od8;
    logic [1:0]  im8, om8;

    logic        iv98, ir98, ov98, or98, busy98;
    logic [97:0] id98, od98;
    logic [1:0]  im98, om98;

    int errs   = 0;
    int checks = 0;

    always #5 clk = ~clk;

    tmodel_iter #(.N(8), .STAGES(3)) u8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .in_data(id8),
        .in_mode(im8), .out_valid(ov8), .out_ready(or8), .out_data(od8),
        .out_mode(om8), .busy(busy8)
    );

    tmodel_iter u98 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv98), .in_ready(ir98), .in_data(id98),
        .in_mode(im98), .out_valid(ov98), .out_ready(or98), .out_data(od98),
        .out_mode(om98), .busy(busy98)
    );

    typedef struct {
        logic [1:0] mode;
        logic [7:0] data;
        logic [7:0] exp;
        int         lat;
    } vec_t;

    vec_t tbl[13];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Element-level reference: stage s xors x[i+2^s] into x[i] for i with bit s clear.
    function automatic logic [127:0] model(input logic [127:0] x, input int n, input int stages,
                                           input logic [1:0] m);
        logic [127:0] w, t;
        w = x;
        if (m[1]) begin
            for (int s = 0; s < stages; s++) begin
                t = w;
                for (int i = 0; i < n; i++) begin
                    if ((i & (1 << s)) == 0 && i + (1 << s) < n) w[i] = t[i] ^ t[i + (1 << s)];
                end
            end
        end
        if (m[0]) begin
            t = w;
            for (int i = 0; i < n; i++) w[i] = t[n-1-i];
        end
        return w;
    endfunction

    task automatic run8(input logic [1:0] m, input logic [7:0] d, input logic [7:0] exp,
                        input int explat, input string name);
        int lat;
        @(negedge clk);
        check({name, " ready"}, 128'(ir8), 128'(1));
        iv8 = 1'b1; im8 = m; id8 = d; or8 = 1'b0;
        @(posedge clk); #1;
        iv8 = 1'b0; id8 = ~d; im8 = ~m;
        lat = 1;
        while (!ov8 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check({name, " lat"}, 128'(lat), 128'(explat));
        check({name, " data"}, 128'(od8), 128'(exp));
        check({name, " mode"}, 128'(om8), 128'(m));
        @(negedge clk); or8 = 1'b1;
        @(posedge clk); #1; or8 = 1'b0;
        check({name, " taken"}, 128'({ov8, ir8, busy8}), 128'(3'b010));
    endtask

    task automatic run98(input logic [1:0] m, input logic [97:0] d, input logic [97:0] exp,
                         input int explat, input int hold, input string name);
        int lat;
        @(negedge clk);
        iv98 = 1'b1; im98 = m; id98 = d; or98 = 1'b0;
        @(posedge clk); #1;
        iv98 = 1'b0; id98 = ~d; im98 = ~m;
        lat = 1;
        while (!ov98 && lat < 30) begin
            @(posedge clk); #1;
            lat++;
        end
        check({name, " lat"}, 128'(lat), 128'(explat));
        check({name, " data"}, 128'(od98), 128'(exp));
        check({name, " mode"}, 128'(om98), 128'(m));
        for (int c = 0; c < hold; c++) begin
            @(posedge clk); #1;
            check({name, " hold"}, 128'({ov98, ir98, od98}), {28'd0, 2'b10, exp});
        end
        @(negedge clk); or98 = 1'b1;
        @(posedge clk); #1; or98 = 1'b0;
        check({name, " taken"}, 128'({ov98, ir98, busy98}), 128'(3'b010));
    endtask

    function automatic int lat_of(input logic [1:0] m, input int stages);
        return (m == 2'b10) ? stages + 1 : (m == 2'b11) ? stages + 2 : 1;
    endfunction

    initial begin
        logic [127:0] r128;
        logic [97:0]  d98;
        logic [7:0]   d8;
        logic [1:0]   m;
        int           lat;
        bit           seen;

        tbl[0]  = '{2'b00, 8'hA5, 8'hA5, 1};
        tbl[1]  = '{2'b00, 8'h00, 8'h00, 1};
        tbl[2]  = '{2'b01, 8'h01, 8'h80, 1};
        tbl[3]  = '{2'b01, 8'h0F, 8'hF0, 1};
        tbl[4]  = '{2'b01, 8'hA6, 8'h65, 1};
        tbl[5]  = '{2'b10, 8'h80, 8'hFF, 4};
        tbl[6]  = '{2'b10, 8'h01, 8'h01, 4};
        tbl[7]  = '{2'b10, 8'h02, 8'h03, 4};
        tbl[8]  = '{2'b10, 8'h10, 8'h11, 4};
        tbl[9]  = '{2'b10, 8'hFF, 8'h80, 4};
        tbl[10] = '{2'b11, 8'h01, 8'h80, 5};
        tbl[11] = '{2'b11, 8'h10, 8'h88, 5};
        tbl[12] = '{2'b11, 8'h08, 8'hF0, 5};

        rst_n = 1'b0;
        iv8 = 1'b0; id8 = '0; im8 = '0; or8 = 1'b0;
        iv98 = 1'b0; id98 = '0; im98 = '0; or98 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset8", 128'({ir8, ov8, busy8, om8, od8}), 128'({3'b100, 2'b00, 8'h00}));
        check("reset98", 128'({ir98, ov98, busy98, om98, od98}), 128'({3'b100, 2'b00, 98'd0}));
        @(negedge clk); rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            run8(tbl[i].mode, tbl[i].data, tbl[i].exp, tbl[i].lat, $sformatf("vec%0d", i));
        end

        run98(2'b00, 98'd4532, 98'd4532, 1, 3, "n98 pass");

        // Back-pressure: result held, stray in_valid ignored, exactly one transfer.
        @(negedge clk); iv8 = 1'b1; im8 = 2'b10; id8 = 8'h80;
        @(posedge clk); #1; iv8 = 1'b0;
        lat = 1;
        while (!ov8 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("bp lat", 128'(lat), 128'(4));
        for (int c = 0; c < 10; c++) begin
            @(negedge clk); iv8 = c[0]; id8 = 8'($urandom); im8 = 2'b00;
            @(posedge clk); #1;
            check("bp hold", 128'({ov8, ir8, om8, od8}), 128'({2'b10, 2'b10, 8'hFF}));
        end
        @(negedge clk); iv8 = 1'b0; or8 = 1'b1;
        @(posedge clk); #1; or8 = 1'b0;
        check("bp take", 128'({ov8, ir8, od8}), 128'({2'b01, 8'hFF}));
        @(posedge clk); #1;
        check("bp once", 128'({ov8, ir8}), 128'(2'b01));

        // Reset at stage 1 with in_valid and out_ready asserted on the same edge.
        @(negedge clk); iv8 = 1'b1; im8 = 2'b10; id8 = 8'h80;
        @(posedge clk); #1; iv8 = 1'b0;
        @(posedge clk); #1;
        check("mid busy", 128'({busy8, ov8}), 128'(2'b10));
        @(negedge clk); rst_n = 1'b0; iv8 = 1'b1; or8 = 1'b1;
        @(posedge clk); #1;
        check("mid reset", 128'({busy8, ov8, ir8, om8, od8}), 128'({3'b001, 2'b00, 8'h00}));
        @(negedge clk); rst_n = 1'b1; iv8 = 1'b0; or8 = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (ov8 || busy8) seen = 1'b1;
        end
        check("no result after reset", 128'(seen), 128'(0));
        run8(2'b10, 8'h80, 8'hFF, 4, "recover");

        // Random back-to-back sweep of all modes against the reference model.
        for (int k = 0; k < 16; k++) begin
            m  = 2'(k);
            d8 = 8'($urandom);
            r128 = model(128'(d8), 8, 3, m);
            run8(m, d8, r128[7:0], lat_of(m, 3), $sformatf("sw8 %0d", k));
        end
        for (int k = 0; k < 8; k++) begin
            m = 2'(k);
            r128 = {$urandom, $urandom, $urandom, $urandom};
            d98 = r128[97:0];
            r128 = model({30'd0, d98}, 98, 7, m);
            run98(m, d98, r128[97:0], lat_of(m, 7), 0, $sformatf("sw98 %0d", k));
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/tmodel_iter.md
TMODEL_ITER -- requirements
Module: tmodel_iter

Interface
REQ-001 Parameter N, default 98: data vector width in bits; N >= 2.
REQ-002 Parameter STAGES, default 7: butterfly stage count; STAGES >= 1 and 2**STAGES >= N, else elaboration error.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 in_valid  input  1  in_data/in_mode valid this cycle.
REQ-006 in_ready  output  1  block can accept a vector this cycle.
REQ-007 in_data  input  N  input vector; bit i = element x[i].
REQ-008 in_mode  input  2  {S2,S1}: 00 pass, 01 bit-reverse, 10 butterfly, 11 butterfly then bit-reverse.
REQ-009 out_valid  output  1  out_data/out_mode valid; held until taken.
REQ-010 out_ready  input  1  consumer accepts the result this cycle.
REQ-011 out_data  output  N  transformed vector.
REQ-012 out_mode  output  2  mode latched with the vector being output.
REQ-013 busy  output  1  high in every state except IDLE.

Function
REQ-014 FSM states IDLE, RUN, REV, DONE; in_ready = (state == IDLE); no overlap of vectors.
REQ-015 Accept = in_valid & in_ready on a clock edge; latches in_data into working register W and in_mode into out_mode; stage counter cleared to 0.
REQ-016 IDLE -> DONE on accept with mode 00; W = in_data.
REQ-017 IDLE -> DONE on accept with mode 01; W = bit-reverse of in_data: W[i] = in_data[N-1-i].
REQ-018 IDLE -> RUN on accept with mode 10 or 11; W = in_data.
REQ-019 RUN, stage s: each edge, for every i with bit s of i = 0 and i + 2**s < N, W[i] <= W[i] ^ W[i + 2**s]; all other bits unchanged; s increments.
REQ-020 RUN exits after the edge applying s = STAGES-1: to DONE for mode 10, to REV for mode 11.
REQ-021 REV: one edge, W[i] <= W[N-1-i], then DONE.
REQ-022 out_data = W, out_valid = (state == DONE); out_data and out_mode stable while out_valid is high and out_ready is low.
REQ-023 DONE -> IDLE on edge with out_ready high; in_ready high in the following cycle.
REQ-024 Latency, accept edge to first out_valid cycle: 1 edge (modes 00/01), STAGES+1 (mode 10), STAGES+2 (mode 11).
REQ-025 in_valid while not IDLE is ignored; in_data/in_mode changes outside the accept edge do not affect the result.
REQ-026 out_ready while not DONE has no effect.
REQ-027 Stage counter width ceil(log2(STAGES+1)); no wrap inside RUN.

Reset
REQ-028 rst_n low at an edge: state IDLE, W = 0, out_mode = 00, stage counter = 0; outputs in_ready=1, out_valid=0, busy=0, out_data=0.
REQ-029 Reset low during RUN, REV or DONE aborts the vector; no result is emitted after reset releases.
REQ-030 Reset has priority over accept and over out_ready on the same edge.

Verification
REQ-031 N=8, STAGES=3, mode 10, in_data=8'h80, out_ready=1 -> out_valid on 4th cycle after accept, out_data=8'hFF, out_mode=10.
REQ-032 N=8, mode 11, in_data=8'h01 -> out_data=8'h80 after 5 edges; mode 01, in_data=8'h01 -> out_data=8'h80 after 1 edge.
REQ-033 Default N=98, mode 00, in_data=4532 -> out_data=4532 one edge after accept; in_ready low until out_ready taken.
REQ-034 Back-pressure: mode 10 with out_ready=0 for 10 cycles -> out_valid and out_data held constant; in_valid pulses ignored; one transfer when out_ready=1.
REQ-035 Reset mid-RUN (assert at stage 1, N=8): next cycle busy=0, out_valid=0, out_data=0; no out_valid until a new accept.
REQ-036 Sweep all four modes back-to-back with random in_data against a bit-level reference model, N=98 and N=8.
